// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle CPU control unit.
// States, opcodes, datapath select codes and phase values.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_FAULT
    } state_t;

    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1100;
    localparam logic [3:0] OP_STA  = 4'b1101;
    localparam logic [3:0] OP_LDA  = 4'b1110;
    localparam logic [3:0] OP_JMP  = 4'b1111;

    localparam logic [1:0] RSEL_IMM = 2'b00;
    localparam logic [1:0] RSEL_RS  = 2'b01;
    localparam logic [1:0] RSEL_RAM = 2'b10;
    localparam logic [1:0] RSEL_ALU = 2'b11;

    localparam logic [1:0] ASEL_PC  = 2'b00;
    localparam logic [1:0] ASEL_IMM = 2'b01;
    localparam logic [1:0] ASEL_RS  = 2'b10;

    localparam logic [1:0] PH_FETCH  = 2'b00;
    localparam logic [1:0] PH_DECODE = 2'b01;
    localparam logic [1:0] PH_EXEC   = 2'b10;
    localparam logic [1:0] PH_STOP   = 2'b11;

    localparam logic [1:0] CC_Z   = 2'b00;
    localparam logic [1:0] CC_NZ  = 2'b01;
    localparam logic [1:0] CC_POS = 2'b10;
    localparam logic [1:0] CC_NEG = 2'b11;

    // Instructions with op[3] set carry an immediate word.
    function automatic logic two_word(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic [1:0] phase_of(input state_t s);
        logic [1:0] p;
        p = PH_STOP;
        unique case (s)
            ST_FETCH:  p = PH_FETCH;
            ST_DECODE: p = PH_DECODE;
            ST_EXEC:   p = PH_EXEC;
            default:   p = PH_STOP;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/control_fsm_cond_eval.sv
// Branch condition evaluator for conditional jumps.
// Maps the 2-bit condition code and ALU flags to a take decision.
import control_pkg::*;

module cond_eval (
    input  logic [1:0] cc,
    input  logic       zero,
    input  logic       negative,
    output logic       take
);

    // Select the flag expression named by the condition code.
    always_comb begin
        take = 1'b0;
        unique case (cc)
            CC_Z:    take = zero;
            CC_NZ:   take = ~zero;
            CC_POS:  take = ~zero & ~negative;
            CC_NEG:  take = negative;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE control unit with memory wait and timeout.
// Optional SINGLE_STEP_EN adds a step input that gates each instruction fetch.
import control_pkg::*;

module control_fsm #(
    parameter int IR_WIDTH   = 8,
    parameter int REG_ADDR_W = 2,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef SINGLE_STEP_EN
    input  logic                  step,
`endif
    input  logic [IR_WIDTH-1:0]   irvalue,
    input  logic                  zero,
    input  logic                  negative,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  readwrite,
    output logic [1:0]            addrsel,
    output logic                  irload,
    output logic                  imload,
    output logic                  pcload,
    output logic                  pcsel,
    output logic [1:0]            regsel,
    output logic                  dwrite,
    output logic [REG_ADDR_W-1:0] dregsel,
    output logic [REG_ADDR_W-1:0] sregsel,
    output logic [1:0]            aluop,
    output logic [1:0]            phase,
    output logic                  halted,
    output logic                  fault
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    if (IR_WIDTH < 4 + 2 * REG_ADDR_W) begin : g_bad_ir
        $error("control_fsm: IR_WIDTH too small for opcode and register fields");
    end
    if (WAIT_LIMIT < 1) begin : g_bad_wait
        $error("control_fsm: WAIT_LIMIT must be at least 1");
    end

    state_t state;
    state_t nxt;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wnxt;

    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic                  take;
    logic                  go;

    logic       req;
    logic       rw;
    logic [1:0] asel;
    logic       ir_ld;
    logic       im_ld;
    logic       pc_ld;
    logic       pc_s;
    logic [1:0] rsel;
    logic       dw;

    assign op = irvalue[IR_WIDTH-1 -: 4];
    assign rd = irvalue[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign rs = irvalue[REG_ADDR_W-1:0];

    cond_eval u_cond (
        .cc       (op[1:0]),
        .zero     (zero),
        .negative (negative),
        .take     (take)
    );

`ifdef SINGLE_STEP_EN
    logic armed;

    // Arm one instruction on a step pulse; disarm once its fetch completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (state == ST_FETCH && !armed && step) begin
            armed <= 1'b1;
        end else if (ir_ld) begin
            armed <= 1'b0;
        end
    end

    assign go = armed;
`else
    assign go = 1'b1;
`endif

    // Decode state, opcode and handshake into strobes and next state.
    always_comb begin
        nxt   = state;
        wnxt  = '0;
        req   = 1'b0;
        rw    = 1'b0;
        asel  = ASEL_PC;
        ir_ld = 1'b0;
        im_ld = 1'b0;
        pc_ld = 1'b0;
        pc_s  = 1'b0;
        rsel  = RSEL_IMM;
        dw    = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_FETCH: begin
                    if (go) begin
                        req = 1'b1;
                        if (mem_ready) begin
                            ir_ld = 1'b1;
                            pc_ld = 1'b1;
                            nxt   = ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    if (two_word(op)) begin
                        req = 1'b1;
                        if (mem_ready) begin
                            im_ld = 1'b1;
                            pc_ld = 1'b1;
                            nxt   = ST_EXEC;
                        end
                    end else begin
                        nxt = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    unique casez (op)
                        4'b00??: begin
                            dw   = 1'b1;
                            rsel = RSEL_ALU;
                            nxt  = ST_FETCH;
                        end
                        OP_LD, OP_LDA: begin
                            req  = 1'b1;
                            asel = (op == OP_LD) ? ASEL_RS : ASEL_IMM;
                            rsel = RSEL_RAM;
                            if (mem_ready) begin
                                dw  = 1'b1;
                                nxt = ST_FETCH;
                            end
                        end
                        OP_ST, OP_STA: begin
                            req  = 1'b1;
                            rw   = 1'b1;
                            asel = (op == OP_ST) ? ASEL_RS : ASEL_IMM;
                            if (mem_ready) begin
                                nxt = ST_FETCH;
                            end
                        end
                        OP_MOV: begin
                            dw   = 1'b1;
                            rsel = RSEL_RS;
                            nxt  = ST_FETCH;
                        end
                        OP_HALT: begin
                            nxt = ST_HALT;
                        end
                        4'b10??: begin
                            pc_ld = take;
                            pc_s  = take;
                            nxt   = ST_FETCH;
                        end
                        OP_LDI: begin
                            dw   = 1'b1;
                            rsel = RSEL_IMM;
                            nxt  = ST_FETCH;
                        end
                        OP_JMP: begin
                            pc_ld = 1'b1;
                            pc_s  = 1'b1;
                            nxt   = ST_FETCH;
                        end
                        default: nxt = ST_FETCH;
                    endcase
                end
                ST_HALT:  nxt = ST_HALT;
                ST_FAULT: nxt = ST_FAULT;
                default:  nxt = ST_FAULT;
            endcase
            // A stalled request either counts on or times out into FAULT.
            if (req && !mem_ready) begin
                if (wcnt == CW'(WAIT_LIMIT - 1)) begin
                    nxt = ST_FAULT;
                end else begin
                    wnxt = wcnt + CW'(1);
                end
            end
        end
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            wcnt  <= '0;
        end else begin
            state <= nxt;
            wcnt  <= wnxt;
        end
    end

    assign mem_req   = req;
    assign readwrite = rw;
    assign addrsel   = asel;
    assign irload    = ir_ld;
    assign imload    = im_ld;
    assign pcload    = pc_ld;
    assign pcsel     = pc_s;
    assign regsel    = rsel;
    assign dwrite    = dw;
    assign dregsel   = reset ? '0 : rd;
    assign sregsel   = reset ? '0 : rs;
    assign aluop     = reset ? 2'b00 : op[1:0];
    assign phase     = reset ? PH_FETCH : phase_of(state);
    assign halted    = !reset && (state == ST_HALT);
    assign fault     = !reset && (state == ST_FAULT);

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm.
// Drives instruction words and memory handshake, checks strobes per cycle.
module tb_control_fsm;

    logic       clk;
    logic       reset;
    logic [7:0] irvalue;
    logic       zero;
    logic       negative;
    logic       mem_ready;
    logic       mem_req;
    logic       readwrite;
    logic [1:0] addrsel;
    logic       irload;
    logic       imload;
    logic       pcload;
    logic       pcsel;
    logic [1:0] regsel;
    logic       dwrite;
    logic [1:0] dregsel;
    logic [1:0] sregsel;
    logic [1:0] aluop;
    logic [1:0] phase;
    logic       halted;
    logic       fault;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    control_fsm #(
        .IR_WIDTH   (8),
        .REG_ADDR_W (2),
        .WAIT_LIMIT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef SINGLE_STEP_EN
        .step      (step),
`endif
        .irvalue   (irvalue),
        .zero      (zero),
        .negative  (negative),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .readwrite (readwrite),
        .addrsel   (addrsel),
        .irload    (irload),
        .imload    (imload),
        .pcload    (pcload),
        .pcsel     (pcsel),
        .regsel    (regsel),
        .dwrite    (dwrite),
        .dregsel   (dregsel),
        .sregsel   (sregsel),
        .aluop     (aluop),
        .phase     (phase),
        .halted    (halted),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        irvalue   = 8'h16;
        zero      = 1'b0;
        negative  = 1'b0;
        mem_ready = 1'b1;
`ifdef SINGLE_STEP_EN
        step      = 1'b0;
`endif
        #1;
        chk("rst_mem_req", 8'(mem_req), 8'h0);
        chk("rst_irload", 8'(irload), 8'h0);
        chk("rst_pcload", 8'(pcload), 8'h0);
        chk("rst_dwrite", 8'(dwrite), 8'h0);
        chk("rst_phase", 8'(phase), 8'h0);
        chk("rst_dregsel", 8'(dregsel), 8'h0);
        chk("rst_halted", 8'(halted), 8'h0);
        chk("rst_fault", 8'(fault), 8'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;

`ifdef SINGLE_STEP_EN
        repeat (4) tick();
        chk("ss_hold_req", 8'(mem_req), 8'h0);
        chk("ss_hold_phase", 8'(phase), 8'h0);
        step = 1'b1;
        #1;
        chk("ss_arm_req", 8'(mem_req), 8'h0);
        tick();
        step = 1'b0;
        #1;
        chk("ss_fetch_req", 8'(mem_req), 8'h1);
        chk("ss_fetch_irload", 8'(irload), 8'h1);
        tick();
        chk("ss_decode", 8'(phase), 8'h1);
        tick();
        chk("ss_exec_dwrite", 8'(dwrite), 8'h1);
        tick();
        chk("ss_back_phase", 8'(phase), 8'h0);
        chk("ss_back_req", 8'(mem_req), 8'h0);
        repeat (3) tick();
        chk("ss_still_req", 8'(mem_req), 8'h0);
`else
        // ALU 0001_01_10 with zero-wait memory
        chk("alu_f_phase", 8'(phase), 8'h0);
        chk("alu_f_req", 8'(mem_req), 8'h1);
        chk("alu_f_addr", 8'(addrsel), 8'h0);
        chk("alu_f_irload", 8'(irload), 8'h1);
        chk("alu_f_pcload", 8'(pcload), 8'h1);
        tick();
        chk("alu_d_phase", 8'(phase), 8'h1);
        chk("alu_d_req", 8'(mem_req), 8'h0);
        tick();
        chk("alu_e_phase", 8'(phase), 8'h2);
        chk("alu_e_dwrite", 8'(dwrite), 8'h1);
        chk("alu_e_regsel", 8'(regsel), 8'h3);
        chk("alu_e_dreg", 8'(dregsel), 8'h1);
        chk("alu_e_sreg", 8'(sregsel), 8'h2);
        chk("alu_e_aluop", 8'(aluop), 8'h1);
        tick();
        chk("alu_next_phase", 8'(phase), 8'h0);
        chk("alu_next_dwrite", 8'(dwrite), 8'h0);

        // JNZ taken (zero=0)
        irvalue = 8'h90;
        #1;
        tick();
        chk("jnz_d_phase", 8'(phase), 8'h1);
        chk("jnz_d_req", 8'(mem_req), 8'h1);
        chk("jnz_d_imload", 8'(imload), 8'h1);
        chk("jnz_d_pcload", 8'(pcload), 8'h1);
        chk("jnz_d_pcsel", 8'(pcsel), 8'h0);
        tick();
        chk("jnz_e_pcload", 8'(pcload), 8'h1);
        chk("jnz_e_pcsel", 8'(pcsel), 8'h1);
        chk("jnz_e_req", 8'(mem_req), 8'h0);
        tick();

        // JNZ not taken (zero=1)
        zero = 1'b1;
        tick();
        tick();
        chk("jnz_nt_phase", 8'(phase), 8'h2);
        chk("jnz_nt_pcload", 8'(pcload), 8'h0);
        tick();
        zero = 1'b0;

        // LD 0100_10_01 with four wait cycles in EXECUTE
        irvalue = 8'h49;
        #1;
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("ld_wait_req", 8'(mem_req), 8'h1);
            chk("ld_wait_dwrite", 8'(dwrite), 8'h0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("ld_done_req", 8'(mem_req), 8'h1);
        chk("ld_done_addr", 8'(addrsel), 8'h2);
        chk("ld_done_dwrite", 8'(dwrite), 8'h1);
        chk("ld_done_regsel", 8'(regsel), 8'h2);
        tick();
        chk("ld_after_phase", 8'(phase), 8'h0);
        chk("ld_after_dwrite", 8'(dwrite), 8'h0);

        // STA 1101_00_11, reset asserted mid-access
        irvalue = 8'hD3;
        #1;
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sta_req", 8'(mem_req), 8'h1);
        chk("sta_rw", 8'(readwrite), 8'h1);
        chk("sta_addr", 8'(addrsel), 8'h1);
        reset = 1'b1;
        #1;
        chk("sta_rst_req", 8'(mem_req), 8'h0);
        chk("sta_rst_rw", 8'(readwrite), 8'h0);
        chk("sta_rst_addr", 8'(addrsel), 8'h0);
        chk("sta_rst_phase", 8'(phase), 8'h0);
        tick();
        reset = 1'b0;
        #1;

        // Memory timeout during FETCH
        repeat (14) tick();
        chk("to_14_fault", 8'(fault), 8'h0);
        chk("to_14_req", 8'(mem_req), 8'h1);
        tick();
        chk("to_15_fault", 8'(fault), 8'h1);
        chk("to_15_phase", 8'(phase), 8'h3);
        chk("to_15_req", 8'(mem_req), 8'h0);
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("to_stay_fault", 8'(fault), 8'h1);
        chk("to_stay_irload", 8'(irload), 8'h0);
        reset = 1'b1;
        #1;
        chk("to_rst_fault", 8'(fault), 8'h0);
        tick();
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;

        // Ready arriving on the last allowed cycle completes normally
        repeat (14) tick();
        irvalue = 8'h70;
        mem_ready = 1'b1;
        #1;
        chk("lim_irload", 8'(irload), 8'h1);
        chk("lim_fault", 8'(fault), 8'h0);
        tick();
        chk("lim_phase", 8'(phase), 8'h1);

        // HALT 0111 becomes absorbing
        tick();
        chk("halt_e_phase", 8'(phase), 8'h2);
        chk("halt_e_req", 8'(mem_req), 8'h0);
        tick();
        chk("halt_halted", 8'(halted), 8'h1);
        chk("halt_phase", 8'(phase), 8'h3);
        repeat (3) tick();
        chk("halt_stay", 8'(halted), 8'h1);
        chk("halt_no_req", 8'(mem_req), 8'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
